servo_adc: RTL and testbench

SERVO_ADC -- requirements
Module: servo_adc

---
 rtl/servo_adc.sv | 200 ++++++++++++++++++++
 tb/tb_servo_adc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_adc.sv
// servo_adc: 1-bit comparator ADC. A sliding window counts comparator ones, a
// servo loop steers a dithered threshold DAC to hold that count at a setpoint,
// and the locked DAC level is reported as the converted sample.
module servo_adc #(
   parameter int unsigned WINDOW_BITS = 1024,
   parameter int unsigned DAC_BITS    = 10,
   parameter int unsigned UPDATE_LOG2 = 21,
   parameter int unsigned LOCK_COUNT  = 8,
   parameter int unsigned INVERT      = 1,
   localparam int unsigned CW         = $clog2(WINDOW_BITS) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                comp_in,
   input  logic                enable,
   input  logic [CW-1:0]       setpoint,
   input  logic [CW-1:0]       tolerance,
   input  logic [3:0]          gain_shift,
   output logic                dac_out,
   output logic [DAC_BITS-1:0] dac_level,
   output logic [CW-1:0]       window_count,
   output logic                sample_valid,
   output logic [DAC_BITS-1:0] sample,
   output logic                locked,
   output logic [1:0]          state
);

   localparam int unsigned EW  = CW + 1;
   localparam int unsigned SW  = ((DAC_BITS > EW) ? DAC_BITS : EW) + 1;
   localparam int unsigned LCW = $clog2(LOCK_COUNT + 1);

   localparam logic [DAC_BITS-1:0] LEVEL_MAX = '1;
   localparam logic [DAC_BITS-1:0] LEVEL_RST = {1'b1, {(DAC_BITS-1){1'b0}}};
   localparam logic [31:0]         LFSR_SEED = 32'hDEADBEEF;
   localparam logic                INV_BIT   = (INVERT != 0);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FILL   = 2'd1;
   localparam logic [1:0] S_SEEK   = 2'd2;
   localparam logic [1:0] S_LOCKED = 2'd3;

   logic                   sync1;
   logic                   sync2;
   logic                   bit_b;
   logic [WINDOW_BITS-1:0] win;
   logic [UPDATE_LOG2-1:0] tick_cnt;
   logic                   tick;
   logic [31:0]            lfsr;
   logic                   lfsr_fb;

   logic [EW-1:0]          err;
   logic [EW-1:0]          mag;
   logic [EW-1:0]          step;
   logic                   neg;
   logic                   band;
   logic [SW-1:0]          up_sum;
   logic [DAC_BITS-1:0]    level_upd;

   logic [1:0]             state_next;
   logic [LCW-1:0]         in_band_cnt;
   logic [LCW-1:0]         in_band_next;
   logic [CW-1:0]          fill_cnt;
   logic [CW-1:0]          fill_next;
   logic [DAC_BITS-1:0]    level_next;
   logic                   strobe;

   assign bit_b   = sync2 ^ INV_BIT;
   assign tick    = &tick_cnt;
   assign lfsr_fb = lfsr[31] ^ lfsr[30] ^ lfsr[10] ^ lfsr[0];

   // Synchronise the comparator and maintain the running ones count of the window
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         win          <= '0;
         window_count <= '0;
      end else begin
         sync1        <= comp_in;
         sync2        <= sync1;
         win          <= {win[WINDOW_BITS-2:0], bit_b};
         window_count <= window_count + CW'(bit_b) - CW'(win[WINDOW_BITS-1]);
      end
   end

   // Free-running servo update timebase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + UPDATE_LOG2'(1);
      end
   end

   // Dither source and threshold comparison driving the DAC pin
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr    <= LFSR_SEED;
         dac_out <= 1'b0;
      end else begin
         lfsr    <= {lfsr_fb, lfsr[31:1]};
         dac_out <= (lfsr[DAC_BITS-1:0] < dac_level);
      end
   end

   // Error magnitude, dead-band test and saturating proportional level step
   always_comb begin
      err       = {1'b0, window_count} - {1'b0, setpoint};
      neg       = err[CW];
      mag       = neg ? (~err + EW'(1)) : err;
      band      = (mag <= {1'b0, tolerance});
      step      = EW'(1) + (mag >> gain_shift);
      up_sum    = SW'(dac_level) + SW'(step);
      level_upd = dac_level;
      if (!band) begin
         if (!neg) begin
            level_upd = (up_sum > SW'(LEVEL_MAX)) ? LEVEL_MAX : up_sum[DAC_BITS-1:0];
         end else begin
            level_upd = (SW'(step) > SW'(dac_level)) ? '0
                                                     : DAC_BITS'(SW'(dac_level) - SW'(step));
         end
      end
   end

   // Servo sequencing: next state, lock qualification, fill timing, level update
   always_comb begin
      state_next   = state;
      in_band_next = in_band_cnt;
      fill_next    = fill_cnt;
      level_next   = dac_level;
      strobe       = 1'b0;
      if (!enable) begin
         state_next   = S_IDLE;
         in_band_next = '0;
         fill_next    = '0;
      end else begin
         case (state)
            S_IDLE: begin
               state_next = S_FILL;
               fill_next  = '0;
            end
            S_FILL: begin
               fill_next = fill_cnt + CW'(1);
               if (fill_cnt == CW'(WINDOW_BITS - 1)) begin
                  state_next = S_SEEK;
               end
            end
            S_SEEK: begin
               if (tick) begin
                  level_next = level_upd;
                  if (band) begin
                     if (in_band_cnt == LCW'(LOCK_COUNT - 1)) begin
                        state_next   = S_LOCKED;
                        in_band_next = '0;
                     end else begin
                        in_band_next = in_band_cnt + LCW'(1);
                     end
                  end else begin
                     in_band_next = '0;
                  end
               end
            end
            default: begin
               if (tick) begin
                  strobe     = 1'b1;
                  level_next = level_upd;
                  if (!band) begin
                     state_next   = S_SEEK;
                     in_band_next = '0;
                  end
               end
            end
         endcase
      end
   end

   // Servo state, level and sample registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         in_band_cnt  <= '0;
         fill_cnt     <= '0;
         dac_level    <= LEVEL_RST;
         locked       <= 1'b0;
         sample       <= '0;
         sample_valid <= 1'b0;
      end else begin
         state        <= state_next;
         in_band_cnt  <= in_band_next;
         fill_cnt     <= fill_next;
         dac_level    <= level_next;
         locked       <= (state_next == S_LOCKED);
         sample_valid <= strobe;
         if (strobe) begin
            sample <= dac_level;
         end
      end
   end

endmodule

// File: tb/tb_servo_adc.sv
// Testbench for servo_adc: directed scenarios plus random stimulus, every
// cycle compared against a behavioural model of the servo ADC.
module tb_servo_adc;

   localparam int W  = 16;
   localparam int DB = 8;
   localparam int UL = 4;
   localparam int LC = 2;
   localparam int CW = 5;
   localparam int LMAX = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          comp_in = 1'b0;
   logic          enable = 1'b0;
   logic [CW-1:0] setpoint = 5'd8;
   logic [CW-1:0] tolerance = 5'd1;
   logic [3:0]    gain_shift = 4'd2;
   logic          dac_out;
   logic [DB-1:0] dac_level;
   logic [CW-1:0] window_count;
   logic          sample_valid;
   logic [DB-1:0] sample;
   logic          locked;
   logic [1:0]    state;

   int n_assert = 0;
   int n_fail   = 0;
   bit alt      = 1'b0;

   // behavioural model state
   bit          m_sync1, m_sync2;
   bit          hist [W];
   int          m_cyc, m_level, m_state, m_ib, m_fill, m_sample;
   bit          m_sv, m_locked, m_dout;
   logic [31:0] m_lfsr;

   servo_adc #(
      .WINDOW_BITS (W),
      .DAC_BITS    (DB),
      .UPDATE_LOG2 (UL),
      .LOCK_COUNT  (LC),
      .INVERT      (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .comp_in      (comp_in),
      .enable       (enable),
      .setpoint     (setpoint),
      .tolerance    (tolerance),
      .gain_shift   (gain_shift),
      .dac_out      (dac_out),
      .dac_level    (dac_level),
      .window_count (window_count),
      .sample_valid (sample_valid),
      .sample       (sample),
      .locked       (locked),
      .state        (state)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of test, expected finish before 400000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int popcount();
      int s = 0;
      for (int i = 0; i < W; i++) s += int'(hist[i]);
      return s;
   endfunction

   task automatic model_reset();
      m_sync1 = 0; m_sync2 = 0;
      for (int i = 0; i < W; i++) hist[i] = 0;
      m_cyc = 0; m_level = 128; m_state = 0; m_ib = 0; m_fill = 0;
      m_sample = 0; m_sv = 0; m_locked = 0; m_dout = 0;
      m_lfsr = 32'hDEADBEEF;
   endtask

   // One clock edge of the reference behaviour, from pre-edge values
   task automatic model_step();
      bit b, tick, band;
      int cnt, err, mag, stp, upd;
      int n_state, n_ib, n_fill, n_level, n_sample;
      bit n_sv;
      b    = m_sync2 ^ 1'b1;
      cnt  = popcount();
      tick = ((m_cyc % (1 << UL)) == (1 << UL) - 1);
      err  = cnt - int'(setpoint);
      mag  = (err < 0) ? -err : err;
      band = (mag <= int'(tolerance));
      stp  = 1 + (mag >> gain_shift);
      if (band)         upd = m_level;
      else if (err > 0) upd = (m_level + stp > LMAX) ? LMAX : m_level + stp;
      else              upd = (m_level - stp < 0) ? 0 : m_level - stp;

      n_state = m_state; n_ib = m_ib; n_fill = m_fill; n_level = m_level;
      n_sample = m_sample; n_sv = 0;
      if (!enable) begin
         n_state = 0; n_ib = 0; n_fill = 0;
      end else if (m_state == 0) begin
         n_state = 1; n_fill = 0;
      end else if (m_state == 1) begin
         n_fill = m_fill + 1;
         if (n_fill == W) n_state = 2;
      end else if (tick) begin
         n_level = upd;
         if (m_state == 2) begin
            if (!band) n_ib = 0;
            else if (m_ib + 1 >= LC) begin n_state = 3; n_ib = 0; end
            else n_ib = m_ib + 1;
         end else begin
            n_sv = 1; n_sample = m_level;
            if (!band) begin n_state = 2; n_ib = 0; end
         end
      end

      m_dout = (int'(m_lfsr[7:0]) < m_level);
      m_lfsr = {m_lfsr[31] ^ m_lfsr[30] ^ m_lfsr[10] ^ m_lfsr[0], m_lfsr[31:1]};
      for (int i = W - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = b;
      m_sync2 = m_sync1;
      m_sync1 = comp_in;
      m_cyc++;
      m_state = n_state; m_ib = n_ib; m_fill = n_fill; m_level = n_level;
      m_sample = n_sample; m_sv = n_sv; m_locked = (n_state == 3);
   endtask

   task automatic compare_all();
      check("window_count", 32'(window_count), 32'(popcount()));
      check("dac_level",    32'(dac_level),    32'(m_level));
      check("state",        32'(state),        32'(m_state));
      check("locked",       32'(locked),       32'(m_locked));
      check("sample_valid", 32'(sample_valid), 32'(m_sv));
      check("sample",       32'(sample),       32'(m_sample));
      check("dac_out",      32'(dac_out),      32'(m_dout));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (alt) comp_in = ~comp_in;
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_dac_level"},    32'(dac_level),    32'd128);
      check({pfx, "_window_count"}, 32'(window_count), 32'd0);
      check({pfx, "_state"},        32'(state),        32'd0);
      check({pfx, "_locked"},       32'(locked),       32'd0);
      check({pfx, "_sample_valid"}, 32'(sample_valid), 32'd0);
      check({pfx, "_sample"},       32'(sample),       32'd0);
      check({pfx, "_dac_out"},      32'(dac_out),      32'd0);
   endtask

   initial begin
      int fill_cycles, nchg, max_wc, pulses, lvl;
      int chg_val [3];
      int chg_cyc [3];
      logic [DB-1:0] prev_lvl;

      // reset values
      #1 rst = 1'b1;
      #2;
      check_reset_values("rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // window fills with comp_in low and never wraps
      max_wc = 0;
      for (int i = 0; i < 24; i++) begin
         cyc();
         if (int'(window_count) > max_wc) max_wc = int'(window_count);
      end
      check("window_full", 32'(window_count), 32'd16);
      check("window_max", 32'(max_wc), 32'd16);

      // enable: FILL for 16 cycles, then level climbs by 3 per tick
      setpoint = 5'd8; tolerance = 5'd1; gain_shift = 4'd2; enable = 1'b1;
      fill_cycles = 0; nchg = 0; prev_lvl = 8'd128;
      for (int k = 0; k < 3; k++) begin chg_val[k] = 0; chg_cyc[k] = 0; end
      for (int i = 0; i < 120 && nchg < 3; i++) begin
         cyc();
         if (state === 2'd1) fill_cycles++;
         if (dac_level !== prev_lvl) begin
            chg_val[nchg] = int'(dac_level);
            chg_cyc[nchg] = i;
            nchg++;
            prev_lvl = dac_level;
         end
      end
      check("fill_cycles", 32'(fill_cycles), 32'd16);
      check("level_changes", 32'(nchg), 32'd3);
      check("level_step1", 32'(chg_val[0]), 32'd131);
      check("level_step2", 32'(chg_val[1]), 32'd134);
      check("level_step3", 32'(chg_val[2]), 32'd137);
      check("tick_gap1", 32'(chg_cyc[1] - chg_cyc[0]), 32'd16);
      check("tick_gap2", 32'(chg_cyc[2] - chg_cyc[1]), 32'd16);
      check("seek_state", 32'(state), 32'd2);

      // upper saturation: 254 + 9 clamps at 255
      gain_shift = 4'd0;
      for (int i = 0; i < 400 && m_level != 254; i++) cyc();
      check("sat_hi_pre", 32'(dac_level), 32'd254);
      for (int i = 0; i < 20 && m_level == 254; i++) cyc();
      check("sat_hi", 32'(dac_level), 32'd255);
      for (int i = 0; i < 20; i++) cyc();
      check("sat_hi_hold", 32'(dac_level), 32'd255);

      // drain the window inside a wide dead-band, then descend to 3 and clamp at 0
      tolerance = 5'd31; comp_in = 1'b1;
      for (int i = 0; i < 24; i++) cyc();
      check("window_empty", 32'(window_count), 32'd0);
      tolerance = 5'd1;
      for (int i = 0; i < 700 && m_level != 3; i++) cyc();
      check("sat_lo_pre", 32'(dac_level), 32'd3);
      for (int i = 0; i < 20 && m_level == 3; i++) cyc();
      check("sat_lo", 32'(dac_level), 32'd0);
      for (int i = 0; i < 20; i++) cyc();
      check("sat_lo_hold", 32'(dac_level), 32'd0);

      // raise the level a little, then hold count at 8 to lock
      gain_shift = 4'd2; comp_in = 1'b0;
      for (int i = 0; i < 40; i++) cyc();
      alt = 1'b1;
      for (int i = 0; i < 120 && !m_locked; i++) cyc();
      check("lock_locked", 32'(locked), 32'd1);
      check("lock_state", 32'(state), 32'd3);
      check("lock_count", 32'(window_count), 32'd8);
      pulses = 0;
      for (int i = 0; i < 64; i++) begin
         cyc();
         if (sample_valid === 1'b1) pulses++;
      end
      check("sample_pulses", 32'(pulses), 32'd4);

      // count moves to 16: drop out of lock on the next tick
      alt = 1'b0; comp_in = 1'b0;
      for (int i = 0; i < 60 && m_locked; i++) cyc();
      check("unlock_locked", 32'(locked), 32'd0);
      check("unlock_state", 32'(state), 32'd2);

      // relock, then asynchronous reset mid-LOCKED
      alt = 1'b1;
      for (int i = 0; i < 120 && !m_locked; i++) cyc();
      check("relock", 32'(locked), 32'd1);
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // lock again from reset, then drop enable
      for (int i = 0; i < 200 && !m_locked; i++) cyc();
      check("relock_after_rst", 32'(locked), 32'd1);
      lvl = m_level;
      enable = 1'b0;
      cyc();
      check("disable_state", 32'(state), 32'd0);
      check("disable_level", 32'(dac_level), 32'(lvl));
      check("disable_locked", 32'(locked), 32'd0);

      // randomized operation
      alt = 1'b0; enable = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) begin
            setpoint   = 5'($urandom_range(0, 16));
            tolerance  = 5'($urandom_range(0, 3));
            gain_shift = 4'($urandom_range(0, 3));
         end
         comp_in = 1'($urandom);
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
